// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic definitions: Kyber prime, coefficient width and
// the add/subtract mode encoding used by the coefficient datapaths.
package mod_arith_pkg;

    localparam int KYBER_Q     = 3329;
    localparam int COEFF_WIDTH = 12;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/mod_addsub_lane.sv
// Single-lane combinational modular adder/subtractor; operands are assumed
// reduced (< MODULUS), so one conditional correction is enough.
module mod_addsub_lane
    import mod_arith_pkg::*;
#(
    parameter int DATA_WIDTH = COEFF_WIDTH,
    parameter int MODULUS    = KYBER_Q
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  mode_e                 mode,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [DATA_WIDTH:0] MOD_EXT = (DATA_WIDTH + 1)'(MODULUS);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] res_add;
    logic [DATA_WIDTH-1:0] res_sub;

    // The extra top bit of diff is the borrow, i.e. the sign of a-b.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};

        if (sum >= MOD_EXT) res_add = DATA_WIDTH'(sum - MOD_EXT);
        else                res_add = sum[DATA_WIDTH-1:0];

        if (diff[DATA_WIDTH]) res_sub = DATA_WIDTH'(diff + MOD_EXT);
        else                  res_sub = diff[DATA_WIDTH-1:0];

        result = (mode == MODE_SUB) ? res_sub : res_add;
    end

endmodule

// File: rtl/mod_addsub_pipeline.sv
// Multi-lane modular add/subtract pipeline with valid/ready handshake.
// Optional sticky operand range check enabled by MOD_ADDSUB_RANGE_CHECK_EN.
module mod_addsub_pipeline
    import mod_arith_pkg::*;
#(
    parameter int DATA_WIDTH  = COEFF_WIDTH,
    parameter int MODULUS     = KYBER_Q,
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        valid_in,
    output logic                        in_ready,
    input  logic                        mode,
    input  logic [LANES*DATA_WIDTH-1:0] a,
    input  logic [LANES*DATA_WIDTH-1:0] b,
    output logic [LANES*DATA_WIDTH-1:0] result,
    output logic                        valid_out,
    input  logic                        out_ready,
    output logic                        range_err
);

    localparam int VW = LANES * DATA_WIDTH;

    logic                   advance;
    logic [PIPE_STAGES-1:0] stage_valid;
    mode_e                  stage_mode [PIPE_STAGES];
    logic [VW-1:0]          stage_a    [PIPE_STAGES];
    logic [VW-1:0]          stage_b    [PIPE_STAGES];

    assign valid_out = stage_valid[PIPE_STAGES-1];
    assign advance   = enable & (~valid_out | out_ready);
    assign in_ready  = advance;

    // Operands and mode travel down the pipe; bubbles shift like real beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                stage_mode[s] <= MODE_ADD;
                stage_a[s]    <= '0;
                stage_b[s]    <= '0;
            end
        end else if (advance) begin
            stage_valid[0] <= valid_in;
            stage_mode[0]  <= mode_e'(mode);
            stage_a[0]     <= a;
            stage_b[0]     <= b;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                stage_valid[s] <= stage_valid[s-1];
                stage_mode[s]  <= stage_mode[s-1];
                stage_a[s]     <= stage_a[s-1];
                stage_b[s]     <= stage_b[s-1];
            end
        end
    end

    // The arithmetic sits on the last stage, so cleared registers give result 0.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mod_addsub_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODULUS    (MODULUS)
        ) u_lane (
            .a      (stage_a[PIPE_STAGES-1][i*DATA_WIDTH +: DATA_WIDTH]),
            .b      (stage_b[PIPE_STAGES-1][i*DATA_WIDTH +: DATA_WIDTH]),
            .mode   (stage_mode[PIPE_STAGES-1]),
            .result (result[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    logic out_of_range;
    logic range_err_q;

    always_comb begin
        out_of_range = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if ((a[i*DATA_WIDTH +: DATA_WIDTH] >= DATA_WIDTH'(MODULUS)) ||
                (b[i*DATA_WIDTH +: DATA_WIDTH] >= DATA_WIDTH'(MODULUS)))
                out_of_range = 1'b1;
        end
    end

    // Sticky: only an accepted beat can set it, only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            range_err_q <= 1'b0;
        else if (advance && valid_in && out_of_range)
            range_err_q <= 1'b1;
    end

    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub_pipeline.sv
// Directed self-checking bench for mod_addsub_pipeline (default parameters).
// Expected range_err behaviour follows MOD_ADDSUB_RANGE_CHECK_EN.
module tb_mod_addsub_pipeline;

    localparam int DW = 12;
    localparam int L  = 4;
    localparam int P  = 3;
    localparam int Q  = 3329;
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          valid_in;
    logic          in_ready;
    logic          mode;
    logic [L*DW-1:0] a;
    logic [L*DW-1:0] b;
    logic [L*DW-1:0] result;
    logic          valid_out;
    logic          out_ready;
    logic          range_err;

    int checks = 0;
    int errors = 0;

    logic [47:0] seq_a [10];
    logic [47:0] seq_b [10];
    logic        seq_m [10];
    logic [47:0] seq_e [10];
    logic [47:0] bp_a  [4];
    logic [47:0] bp_b  [4];
    logic        bp_m  [4];
    logic [47:0] bp_e  [4];
    int          sent;
    int          recv;

    always #5 clk = ~clk;

    mod_addsub_pipeline #(
        .DATA_WIDTH  (DW),
        .MODULUS     (Q),
        .LANES       (L),
        .PIPE_STAGES (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .result    (result),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .range_err (range_err)
    );

    function automatic logic [47:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {12'(l3), 12'(l2), 12'(l1), 12'(l0)};
    endfunction

    // Reference uses plain integer remainder arithmetic, independent of the RTL structure.
    function automatic logic [47:0] ref_beat(input logic [47:0] av, input logic [47:0] bv, input logic m);
        logic [47:0] r;
        int x, y, z;
        r = '0;
        for (int i = 0; i < L; i++) begin
            x = int'(av[i*DW +: DW]);
            y = int'(bv[i*DW +: DW]);
            z = m ? (x - y + Q) % Q : (x + y) % Q;
            r[i*DW +: DW] = 12'(z);
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic v, input logic m, input logic [47:0] av, input logic [47:0] bv);
        valid_in = v;
        mode     = m;
        a        = av;
        b        = bv;
    endtask

    task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < L; i++) begin
                seq_a[k][i*DW +: DW] = 12'((k * 400 + i * 37) % Q);
                seq_b[k][i*DW +: DW] = 12'(3000 - k * 150 + i * 11);
            end
            seq_m[k] = k[0];
            seq_e[k] = ref_beat(seq_a[k], seq_b[k], seq_m[k]);
        end
        for (int k = 0; k < 4; k++) begin
            bp_a[k] = pack4(100 * k + 5, 3328 - k, 17 * k, 2000 + k);
            bp_b[k] = pack4(3000 - k, 7 * k + 1, 3328, 1500 + 3 * k);
            bp_m[k] = ~k[0];
            bp_e[k] = ref_beat(bp_a[k], bp_b[k], bp_m[k]);
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_valid_out", 48'(valid_out), 48'd0);
        checkOutput("reset_result", result, 48'd0);
        checkOutput("reset_range_err", 48'(range_err), 48'd0);
        checkOutput("reset_in_ready_disabled", 48'(in_ready), 48'd0);
        rst_n     = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Subtract beat with borrow/wrap corner lanes
        applyStimulus(1'b1, 1'b1, pack4(100, 0, 0, 3328), pack4(200, 1, 3328, 3328));
        #1 checkOutput("sub_in_ready", 48'(in_ready), 48'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("sub_latency_1", 48'(valid_out), 48'd0);
        @(negedge clk);
        checkOutput("sub_latency_2", 48'(valid_out), 48'd0);
        @(negedge clk);
        checkOutput("sub_valid", 48'(valid_out), 48'd1);
        checkOutput("sub_result", result, pack4(3229, 3328, 1, 0));
        @(negedge clk);
        checkOutput("sub_single_beat", 48'(valid_out), 48'd0);

        // Add beat with reduction corners
        applyStimulus(1'b1, 1'b0, pack4(3000, 3328, 0, 1000), pack4(500, 1, 0, 2000));
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("add_valid", 48'(valid_out), 48'd1);
        checkOutput("add_result", result, pack4(171, 0, 0, 3000));
        @(negedge clk);

        // Ten back-to-back beats, alternating mode
        for (int t = 0; t < 13; t++) begin
            if (t < 10) applyStimulus(1'b1, seq_m[t], seq_a[t], seq_b[t]);
            else        applyStimulus(1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (t >= 2 && t <= 11) begin
                checkOutput($sformatf("b2b_valid_%0d", t - 2), 48'(valid_out), 48'd1);
                checkOutput($sformatf("b2b_result_%0d", t - 2), result, seq_e[t - 2]);
            end else if (t == 12) begin
                checkOutput("b2b_drained", 48'(valid_out), 48'd0);
            end
        end

        // Backpressure: out_ready low for 4 cycles while a result is waiting
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 7);
            if (sent < 4) applyStimulus(1'b1, bp_m[sent], bp_a[sent], bp_b[sent]);
            else          applyStimulus(1'b0, 1'b0, '0, '0);
            #1;
            if (valid_out && !out_ready) begin
                checkOutput($sformatf("bp_in_ready_low_c%0d", cyc), 48'(in_ready), 48'd0);
                checkOutput($sformatf("bp_frozen_c%0d", cyc), result, bp_e[recv]);
            end
            if (valid_out && out_ready) begin
                checkOutput($sformatf("bp_order_%0d", recv), result, bp_e[recv]);
                recv++;
            end
            if (valid_in && in_ready) sent++;
            @(negedge clk);
        end
        checkOutput("bp_received_count", 48'(recv), 48'd4);
        checkOutput("bp_no_duplicate", 48'(valid_out), 48'd0);
        out_ready = 1'b1;

        // Reset with three beats in flight
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1'b1, seq_m[t], seq_a[t], seq_b[t]);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("pre_reset_valid", 48'(valid_out), 48'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid_out", 48'(valid_out), 48'd0);
        checkOutput("async_reset_result", result, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checkOutput($sformatf("no_stale_%0d", t), 48'(valid_out), 48'd0);
        end
        applyStimulus(1'b1, seq_m[5], seq_a[5], seq_b[5]);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("post_reset_latency", 48'(valid_out), 48'd0);
        @(negedge clk);
        checkOutput("post_reset_valid", 48'(valid_out), 48'd1);
        checkOutput("post_reset_result", result, seq_e[5]);
        @(negedge clk);

        // Range check on an out-of-range lane-2 operand
        checkOutput("range_err_baseline", 48'(range_err), 48'd0);
        applyStimulus(1'b1, 1'b0, pack4(5, 6, 3329, 7), pack4(1, 1, 1, 1));
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("range_err_set", 48'(range_err), 48'(RC));
        for (int t = 0; t < 3; t++) @(negedge clk);
        checkOutput("range_err_sticky", 48'(range_err), 48'(RC));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mod_addsub_pipeline.md
MOD_ADDSUB_PIPELINE -- requirements
Module: mod_addsub_pipeline

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, coefficient width in bits.
REQ-002 SHALL have parameter MODULUS, default 3329, the prime q; SHALL satisfy MODULUS < 2**DATA_WIDTH.
REQ-003 SHALL have parameter LANES, default 4, number of independent coefficient lanes.
REQ-004 SHALL have parameter PIPE_STAGES, default 3, latency in advancing cycles; legal range 1..4.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, global run; low freezes the pipeline.
REQ-008 SHALL have port valid_in, input, 1, input beat present.
REQ-009 SHALL have port in_ready, output, 1, input beat accepted this cycle when high with valid_in.
REQ-010 SHALL have port mode, input, 1, 0 = modular add, 1 = modular subtract; applies to all lanes of the beat.
REQ-011 SHALL have port a, input, LANES*DATA_WIDTH, packed operands; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port b, input, LANES*DATA_WIDTH, packed operands, same packing.
REQ-013 SHALL have port result, output, LANES*DATA_WIDTH, packed results, same packing.
REQ-014 SHALL have port valid_out, output, 1, result beat present.
REQ-015 SHALL have port out_ready, input, 1, downstream accepts result when high with valid_out.
REQ-016 SHALL have port range_err, output, 1, sticky flag that an out-of-range operand was accepted.

Function
REQ-017 SHALL compute per lane, add: s = a+b over DATA_WIDTH+1 bits; result = s-MODULUS if s >= MODULUS, else s.
REQ-018 SHALL compute per lane, subtract: d = a-b signed over DATA_WIDTH+1 bits; result = d+MODULUS if d < 0, else d.
REQ-019 SHALL define advance = enable AND (NOT valid_out OR out_ready); in_ready SHALL equal advance.
REQ-020 SHALL shift all stages, bubbles included, by one on each cycle with advance high; no stage changes when advance is low.
REQ-021 SHALL present a beat accepted at edge N on result/valid_out after exactly PIPE_STAGES advancing edges, with mode carried alongside the data.
REQ-022 SHALL hold result and valid_out stable while valid_out=1 and out_ready=0.
REQ-023 SHALL, when valid_in=1 and in_ready=0, ignore the beat; the source holds it.
REQ-024 SHALL sustain one beat per cycle when enable=1 and out_ready=1, in strict order.
REQ-025 SHALL give identical results for every lane regardless of other lanes' values.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all stage valid bits, all data registers, result to 0, valid_out to 0 and range_err to 0.
REQ-027 SHALL discard in-flight beats on reset mid-operation; first valid_out after release only for beats accepted after release.

Configuration
REQ-028 SHALL, with macro MOD_ADDSUB_RANGE_CHECK_EN defined, set range_err on the edge accepting a beat where any lane of a or b >= MODULUS; cleared only by reset.
REQ-029 SHALL, without MOD_ADDSUB_RANGE_CHECK_EN, tie range_err to 0 and contain no check logic; datapath identical either way.

Structure
REQ-030 SHALL take defaults KYBER_Q = 3329, COEFF_WIDTH = 12 and the mode encoding (MODE_ADD = 0, MODE_SUB = 1) from shared package mod_arith_pkg.
REQ-031 SHALL implement per-lane arithmetic in one combinational sub-module mod_addsub_lane, instantiated LANES times; stage registers and handshake live in the top.

Verification
REQ-032 SHALL cover: sub lane0 100,200; lane1 0,1; lane2 0,3328; lane3 3328,3328; out_ready=1 -> 3229, 3328, 1, 0 after 3 cycles.
REQ-033 SHALL cover: add lane0 3000+500; lane1 3328+1; lane2 0+0; lane3 1000+2000 -> 171, 0, 0, 3000.
REQ-034 SHALL cover: 10 back-to-back beats alternating mode, out_ready=1 -> 10 in-order results on 10 consecutive cycles starting 3 cycles after first accept.
REQ-035 SHALL cover: out_ready low 4 cycles with valid_out=1 -> result frozen, in_ready=0, no beat lost or duplicated after release.
REQ-036 SHALL cover: rst_n pulsed low with 3 beats in flight -> valid_out=0 and result=0 immediately, no stale beats after release.
REQ-037 SHALL cover, with MOD_ADDSUB_RANGE_CHECK_EN: accept a=3329 on lane 2 -> range_err=1 next cycle and stays 1; without macro range_err stays 0.
